cycle_sequencer: RTL
====================

# cycle_sequencer

Timing generator for the CPU control unit: produces the one-hot T-state (`o_Cycle_Step`) and M-cycle (`o_Cycle_Count`) vectors that every opcode-quadrant decoder consumes.
- Advances T1..T4 within each machine cycle and steps the M-cycle index.
- Restarts at M1 when a decoder signals instruction fetch.
- Stretches T2 for bus wait states.
- Parks the core in HALT until wake.

## Interface
Parameters:
- none

Ports:
- `i_Clk`  in  1  system clock; all state changes on rising edge
- `i_Rst_N`  in  1  asynchronous, active-low reset
- `i_Enable`  in  1  clock enable; low freezes all state and suppresses pulses
- `i_IR_Fetch`  in  1  OR of decoder fetch requests; sampled at T4: current M-cycle is the instruction's last
- `i_Halt`  in  1  OR of decoder halt requests; sampled at T4
- `i_Wake`  in  1  interrupt pending / wake request; level, sampled in HALT
- `i_Bus_Wait`  in  1  memory not ready; sampled at T2
- `o_Cycle_Step`  out  4  one-hot T-state: bit0=T1 … bit3=T4; all-zero in HALT
- `o_Cycle_Count`  out  8  one-hot M-cycle: bit0=M1 … bit7=M8; all-zero in HALT
- `o_Instr_Done`  out  1  one-cycle pulse, coincident with T1 of a new M1
- `o_Halted`  out  1  high while in HALT
- `o_Seq_Error`  out  1  sticky: M8 ended without fetch or halt

## Operation
- **States:**
  - RUN: step rotates each enabled cycle.
  - HALT: step and count are zero.
- **Reset** (async, `i_Rst_N` low) gives:
  - state RUN
  - `o_Cycle_Step` = 4'b0001
  - `o_Cycle_Count` = 8'b00000001
  - `o_Instr_Done` = 0
  - `o_Halted` = 0
  - `o_Seq_Error` = 0
- **RUN, step T1/T3:** next step is the following T-state.
- **RUN, step T2:**
  - If `i_Bus_Wait` = 1: hold T2.
  - Otherwise: advance to T3.
  - Wait is ignored in T1/T3/T4.
- **RUN, step T4** (priority high → low):
  1. `i_Halt` = 1: go to HALT; step and count become 0; `o_Halted` = 1.
  2. `i_IR_Fetch` = 1: step = T1, count = M1, `o_Instr_Done` pulses.
  3. count = M8: set `o_Seq_Error`; step = T1, count = M1; no done pulse.
  4. Otherwise: step = T1; count shifts left one position.
- **HALT:**
  - If `i_Wake` = 1: next state RUN, step = T1, count = M1, `o_Instr_Done` pulses, `o_Halted` = 0.
  - Otherwise: remain in HALT.
  - HALT lasts at least one clock, even if `i_Wake` is already high on entry.
- **Wake in RUN:** `i_Wake` is ignored.
- **`o_Seq_Error`:** cleared only by reset.
- **`i_Enable` = 0:** every register holds, and `o_Instr_Done` is forced 0 that cycle.
- **Invariant:** in RUN, step and count are always exactly one-hot.

## Timing
- All outputs are registered, and none depend combinationally on inputs.
- The next T-state appears one clock after the sampled edge.
- An unstalled M-cycle is 4 enabled clocks. Each T2 wait adds 1 clock.
- Fetch at M1/T4 leads to M1/T1 with `o_Instr_Done` = 1 on the very next clock.
- The done pulse is exactly one enabled cycle wide.
- Halt at T4 means `o_Halted` = 1 one clock later.
- Wake is seen in HALT; RUN resumes at T1 of M1 one clock later.
- Reset asserted mid-M-cycle or during HALT forces reset values immediately, without waiting for a clock.
- After release, the first edge advances T1 → T2.
- `i_Halt` and `i_IR_Fetch` asserted together at T4: HALT wins, and no done pulse is produced.

## Test plan
- **Reset then free-run:** hold fetch = 0 for 4 M-cycles.
  - Step sequence: 1, 2, 4, 8 repeating.
  - Count sequence: 01, 02, 04, 08.
  - Then assert fetch at the T4 of M4: count = 01, `o_Instr_Done` = 1 for one clock.
- **Wait states:** assert `i_Bus_Wait` for 3 clocks while at T2 of M1.
  - Step stays 4'b0010 for 4 clocks, then T3.
  - The M-cycle takes 7 clocks.
- **Halt/wake:**
  - `i_Halt` = 1 at M1/T4: step = 0, count = 0, `o_Halted` = 1.
  - Hold for 10 clocks; state is unchanged.
  - `i_Wake` = 1: next clock step = 1, count = 01, done = 1, halted = 0.
- **Simultaneous halt + fetch at T4:** enters HALT, done stays 0.
- **Overflow:** fetch held 0 through M8/T4.
  - Count wraps to 01 and `o_Seq_Error` = 1.
  - Error stays 1 after later normal instructions, and clears only on reset.
- **Enable and async reset:**
  - `i_Enable` low for 5 clocks at T3/M2: outputs frozen, no pulses.
  - Pulse `i_Rst_N` low between clock edges during HALT: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: one-hot T-state / M-cycle timing generator with wait stretch and HALT parking
module cycle_sequencer (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Enable,
  input  logic       i_IR_Fetch,
  input  logic       i_Halt,
  input  logic       i_Wake,
  input  logic       i_Bus_Wait,
  output logic [3:0] o_Cycle_Step,
  output logic [7:0] o_Cycle_Count,
  output logic       o_Instr_Done,
  output logic       o_Halted,
  output logic       o_Seq_Error
);
  typedef enum logic {RUN, HALT} state_t;
  state_t     state_q;
  logic [3:0] step_q;
  logic [7:0] count_q;
  logic       done_q, halted_q, err_q;
  // sequencer: T-state rotation, M-cycle stepping at T4, HALT entry/exit; done is a single-cycle pulse
  always_ff @(posedge i_Clk or negedge i_Rst_N)
    if (!i_Rst_N) begin
      state_q  <= RUN;
      step_q   <= 4'b0001;
      count_q  <= 8'b00000001;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (!i_Enable) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == HALT) begin
        if (i_Wake) begin
          state_q  <= RUN;
          step_q   <= 4'b0001;
          count_q  <= 8'b00000001;
          done_q   <= 1'b1;
          halted_q <= 1'b0;
        end
      end else if (step_q[3]) begin
        if (i_Halt) begin
          state_q  <= HALT;
          step_q   <= 4'b0000;
          count_q  <= 8'b00000000;
          halted_q <= 1'b1;
        end else if (i_IR_Fetch) begin
          step_q  <= 4'b0001;
          count_q <= 8'b00000001;
          done_q  <= 1'b1;
        end else if (count_q[7]) begin
          err_q   <= 1'b1;
          step_q  <= 4'b0001;
          count_q <= 8'b00000001;
        end else begin
          step_q  <= 4'b0001;
          count_q <= count_q << 1;
        end
      end else if (!(step_q[1] && i_Bus_Wait)) begin
        step_q <= step_q << 1;
      end
    end
  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_Instr_Done  = done_q;
  assign o_Halted      = halted_q;
  assign o_Seq_Error   = err_q;
endmodule
